noc_frm_arb: RTL

- Parametrised N-channel frame merger for the NOC interface return path.
- Each channel buffers a stream of frame bytes (control flag, last flag, data) in its own FIFO.
- A packet-atomic round-robin arbiter merges the channels onto one registered frm_ctl/frm_data link.
- Next-generation replacement for the single-source frm path: scales channel count, data width and buffering, and adds stall and protocol checking.

---
 rtl/noc_frm_arb.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/noc_frm_arb.sv
// N-channel frame merger: per-channel byte FIFOs feeding a packet-atomic
// round-robin arbiter that drives one registered frm_* link.
module noc_frm_arb #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         in_vld,
    input  logic [NCH-1:0]         in_ctl,
    input  logic [NCH-1:0]         in_last,
    input  logic [NCH*DW-1:0]      in_data,
    output logic [NCH-1:0]         in_stop,
    input  logic                   out_stop,
    output logic                   frm_vld,
    output logic                   frm_ctl,
    output logic                   frm_last,
    output logic [DW-1:0]          frm_data,
    output logic [$clog2(NCH)-1:0] frm_ch,
    output logic                   proto_err
);

    localparam int unsigned CHW = $clog2(NCH);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned EW  = DW + 2;

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } state_e;

    // FIFO storage, entry = {ctl, last, data}
    logic [EW-1:0]  mem_q    [NCH][DEPTH];
    logic [AW-1:0]  wr_ptr_q [NCH];
    logic [AW-1:0]  rd_ptr_q [NCH];
    logic [AW:0]    cnt_q    [NCH];

    logic [NCH-1:0] nonempty;
    logic [NCH-1:0] wr_en;
    logic [NCH-1:0] pop_en;

    state_e         state_q, state_d;
    logic [CHW-1:0] grant_q, grant_d;
    logic [CHW-1:0] rr_q, rr_d;
    logic           first_q, first_d;

    logic           frm_vld_q, frm_vld_d;
    logic           frm_ctl_q, frm_ctl_d;
    logic           frm_last_q, frm_last_d;
    logic [DW-1:0]  frm_data_q, frm_data_d;
    logic [CHW-1:0] frm_ch_q, frm_ch_d;
    logic           proto_err_q, proto_err_d;

    logic [CHW-1:0] rr_pick;
    logic           any_ne;
    logic [EW-1:0]  head;

    always_comb begin
        nonempty = '0;
        in_stop  = '0;
        wr_en    = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
            in_stop[i]  = (cnt_q[i] == (AW+1)'(DEPTH));
            wr_en[i]    = in_vld[i] & ~in_stop[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (wr_en[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
                end
                if (pop_en[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                end
                if (wr_en[i] && !pop_en[i]) begin
                    cnt_q[i] <= cnt_q[i] + (AW+1)'(1);
                end else if (!wr_en[i] && pop_en[i]) begin
                    cnt_q[i] <= cnt_q[i] - (AW+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NCH; i++) begin
            if (reset && wr_en[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {in_ctl[i], in_last[i], in_data[i*DW +: DW]};
            end
        end
    end

    // First non-empty channel after rr_q, wrapping modulo NCH
    always_comb begin
        int unsigned idx;
        idx     = 0;
        rr_pick = rr_q;
        any_ne  = 1'b0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!any_ne && nonempty[CHW'(idx)]) begin
                any_ne  = 1'b1;
                rr_pick = CHW'(idx);
            end
        end
    end

    assign head = mem_q[grant_q][rd_ptr_q[grant_q]];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        first_d     = first_q;
        pop_en      = '0;
        frm_vld_d   = frm_vld_q;
        frm_ctl_d   = frm_ctl_q;
        frm_last_d  = frm_last_q;
        frm_data_d  = frm_data_q;
        frm_ch_d    = frm_ch_q;
        proto_err_d = 1'b0;

        // Stall freezes outputs and FSM; otherwise default to the idle token
        if (!out_stop) begin
            frm_vld_d  = 1'b0;
            frm_ctl_d  = 1'b1;
            frm_last_d = 1'b0;
            frm_data_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (any_ne) begin
                        grant_d = rr_pick;
                        first_d = 1'b1;
                        state_d = ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (nonempty[grant_q]) begin
                        pop_en[grant_q] = 1'b1;
                        frm_vld_d       = 1'b1;
                        frm_ctl_d       = head[DW+1];
                        frm_last_d      = head[DW];
                        frm_data_d      = head[DW-1:0];
                        frm_ch_d        = grant_q;
                        proto_err_d     = first_q ? ~head[DW+1] : head[DW+1];
                        first_d         = 1'b0;
                        if (head[DW]) begin
                            rr_d    = grant_q;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_q        <= CHW'(NCH - 1);
            first_q     <= 1'b0;
            frm_vld_q   <= 1'b0;
            frm_ctl_q   <= 1'b1;
            frm_last_q  <= 1'b0;
            frm_data_q  <= '0;
            frm_ch_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            first_q     <= first_d;
            frm_vld_q   <= frm_vld_d;
            frm_ctl_q   <= frm_ctl_d;
            frm_last_q  <= frm_last_d;
            frm_data_q  <= frm_data_d;
            frm_ch_q    <= frm_ch_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign frm_vld   = frm_vld_q;
    assign frm_ctl   = frm_ctl_q;
    assign frm_last  = frm_last_q;
    assign frm_data  = frm_data_q;
    assign frm_ch    = frm_ch_q;
    assign proto_err = proto_err_q;

endmodule
